filter_buffer_kxk: RTL and testbench

FILTER_BUFFER_KXK -- requirements
Module: filter_buffer_kxk

---
 rtl/filter_buffer_kxk.sv | 193 +++++++++++++++++++
 tb/tb_filter_buffer_kxk.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_buffer_kxk.sv
// filter_buffer_kxk: captures K x K coefficient filters one row at a time and
// presents a complete, stable filter to a downstream consumer.
// Kernel size is 3x3 or K_MAX x K_MAX. For 3x3 filters, the unused words and
// rows are forced to zero on the output.
// Build option: define FILTER_BUF_PINGPONG_EN to build two banks, so a new
// filter can load while the consumer still uses the active one. Without it,
// one bank is built and loading stalls while the filter is in use.
module filter_buffer_kxk #(
    parameter int DATA_W = 16,
    parameter int K_MAX  = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ksize_max,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [K_MAX*DATA_W-1:0]         in_row,
    output logic                            load_done,
    output logic                            out_valid,
    output logic [K_MAX*K_MAX*DATA_W-1:0]   out_filter,
    output logic                            out_ksize_max,
    input  logic                            out_release
);

`ifdef FILTER_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    localparam int            CW       = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [CW-1:0] LAST_3   = CW'(2);
    localparam logic [CW-1:0] LAST_MAX = CW'(K_MAX - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       promote;

    logic [CW-1:0]              row_cnt;
    logic                       ks_lat;
    logic                       ks_eff;
    logic                       act_valid;
    logic                       xfer;
    logic                       last_xfer;
    logic                       rel;

    logic [K_MAX*DATA_W-1:0]    bank_row [NB][K_MAX];
    logic                       bank_ks  [NB];
    logic [NB-1:0]              bank_we;

    logic [K_MAX*DATA_W-1:0]    act_row  [K_MAX];
    logic                       act_ks;

    // Handshake and row bookkeeping. The kernel size seen on the row-0
    // transfer governs the whole filter; later ksize_max changes are ignored.
    assign xfer      = in_valid && in_ready;
    assign ks_eff    = (row_cnt == '0) ? ksize_max : ks_lat;
    assign last_xfer = xfer && (row_cnt == (ks_eff ? LAST_MAX : LAST_3));
    assign rel       = out_release && act_valid;

    // Loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Loader next state: a completed filter is promoted at once when the
    // active slot is free (or being freed on this edge), otherwise it waits.
    always_comb begin
        state_next = state;
        promote    = 1'b0;
        case (state)
            S_LOAD: begin
                if (last_xfer) begin
                    if (!act_valid || rel) begin
                        promote = 1'b1;
                    end else begin
                        state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (rel) begin
                    promote    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Loader outputs: accept rows only in LOAD, never while held in reset
    always_comb begin
`ifdef FILTER_BUF_PINGPONG_EN
        in_ready = rst_n && (state == S_LOAD);
`else
        in_ready = rst_n && (state == S_LOAD) && !act_valid;
`endif
    end

    // Row counter, size latch, active-filter flag and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            ks_lat    <= 1'b0;
            act_valid <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= last_xfer;
            if (xfer) begin
                row_cnt <= last_xfer ? '0 : row_cnt + CW'(1);
                if (row_cnt == '0) begin
                    ks_lat <= ksize_max;
                end
            end
            if (promote) begin
                act_valid <= 1'b1;
            end else if (rel) begin
                act_valid <= 1'b0;
            end
        end
    end

`ifdef FILTER_BUF_PINGPONG_EN
    logic load_sel;
    logic act_sel;

    // Bank roles swap whenever the load bank is promoted to active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sel <= 1'b0;
            act_sel  <= 1'b0;
        end else if (promote) begin
            act_sel  <= load_sel;
            load_sel <= ~load_sel;
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_we
        assign bank_we[gi] = xfer && (load_sel == 1'(gi));
    end

    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_act
        assign act_row[gi] = bank_row[act_sel][gi];
    end
    assign act_ks = bank_ks[act_sel];
`else
    // Single bank: it is loaded and presented in turn, never both at once
    assign bank_we = {NB{xfer}};

    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_act
        assign act_row[gi] = bank_row[0][gi];
    end
    assign act_ks = bank_ks[0];
`endif

    // Coefficient banks: one row written per transfer
    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int r = 0; r < K_MAX; r++) begin
                    bank_row[gi][r] <= '0;
                end
                bank_ks[gi] <= 1'b0;
            end else if (bank_we[gi]) begin
                bank_row[gi][row_cnt] <= in_row;
                bank_ks[gi]           <= ks_eff;
            end
        end
    end

    // Output view: zero when no filter is active, and outside the 3x3
    // corner for small kernels (the bank may still hold older data there).
    for (genvar gi = 0; gi < K_MAX; gi++) begin : g_orow
        for (genvar gj = 0; gj < K_MAX; gj++) begin : g_ocol
            localparam bit IN3 = (gi < 3) && (gj < 3);
            assign out_filter[(gi*K_MAX+gj)*DATA_W +: DATA_W] =
                (act_valid && (act_ks || IN3)) ? act_row[gi][gj*DATA_W +: DATA_W] : '0;
        end
    end

    assign out_valid     = act_valid;
    assign out_ksize_max = act_valid && act_ks;

endmodule

// File: tb/tb_filter_buffer_kxk.sv
// Testbench for filter_buffer_kxk. Expected filters are queued as loads are
// issued; a monitor pops and compares whenever a new filter is presented and
// checks that the active filter stays stable otherwise.
// Covers the FILTER_BUF_PINGPONG_EN build when that macro is defined.
module tb_filter_buffer_kxk;
    localparam int DATA_W = 16;
    localparam int K_MAX  = 5;
    localparam int RW     = K_MAX * DATA_W;
    localparam int FW     = K_MAX * K_MAX * DATA_W;

`ifdef FILTER_BUF_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ksize_max = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_row = '0;
    logic          load_done;
    logic          out_valid;
    logic [FW-1:0] out_filter;
    logic          out_ksize_max;
    logic          out_release = 1'b0;

    int checks    = 0;
    int failures  = 0;
    int presented = 0;
    int pushed    = 0;

    typedef struct {
        logic [FW-1:0] filt;
        logic          ks;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   prev_valid = 1'b0;
    bit   rel_prev   = 1'b0;

    filter_buffer_kxk #(
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ksize_max     (ksize_max),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_row        (in_row),
        .load_done     (load_done),
        .out_valid     (out_valid),
        .out_filter    (out_filter),
        .out_ksize_max (out_ksize_max),
        .out_release   (out_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] wval(input int base, input int mult, input int r, input int c);
        int v;
        v = base + mult * (r * K_MAX + c);
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [RW-1:0] make_row(input int base, input int mult, input int r);
        logic [RW-1:0] row;
        for (int c = 0; c < K_MAX; c++) begin
            row[c*DATA_W +: DATA_W] = wval(base, mult, r, c);
        end
        return row;
    endfunction

    // Present one row and hold it until the DUT accepts it (bounded wait)
    task automatic send_row(input logic [RW-1:0] row, input bit ks, input bit rel);
        bit ok;
        ok          = 1'b0;
        in_valid    = 1'b1;
        in_row      = row;
        ksize_max   = ks;
        out_release = rel;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        out_release = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_row_timeout: in_ready got 0 required 1");
        end
    endtask

    // Load rows first_row..nrows-1 of a filter whose word (r,c) is
    // base + mult*(r*K_MAX+c); the expected filter is queued with the last row.
    task automatic load_filter(input bit ks, input int base, input int mult, input int first_row,
                               input int nrows, input bit toggle, input bit rel_last);
        int   k;
        exp_t e;
        k      = ks ? K_MAX : 3;
        e.ks   = ks;
        e.filt = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                e.filt[(r*K_MAX+c)*DATA_W +: DATA_W] = wval(base, mult, r, c);
            end
        end
        for (int r = first_row; r < nrows; r++) begin
            if (r == k - 1) begin
                exp_q.push_back(e);
                pushed++;
            end
            send_row(make_row(base, mult, r), (toggle && r > 0) ? ~ks : ks, rel_last && (r == k - 1));
        end
    endtask

    task automatic pulse_release();
        out_release = 1'b1;
        @(posedge clk);
        #1;
        out_release = 1'b0;
    endtask

    // Monitor: compare each newly presented filter, check stability otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            rel_prev   = 1'b0;
        end else begin
            if (out_valid && (!prev_valid || rel_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_filter: got a presented filter, required none pending");
                end else begin
                    cur = exp_q.pop_front();
                    presented++;
                    chk("filter_content", out_filter, cur.filt);
                    chk("filter_ksize", out_ksize_max, cur.ks);
                    $display("filter %0d presented ksize_max=%0b word0=%0h word24=%0h", presented,
                             out_ksize_max, out_filter[DATA_W-1:0], out_filter[24*DATA_W +: DATA_W]);
                end
            end else if (out_valid) begin
                chk("filter_stable", out_filter, cur.filt);
                chk("ksize_stable", out_ksize_max, cur.ks);
            end
            prev_valid = out_valid;
            rel_prev   = out_valid && out_release;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur.filt = '0;
        cur.ks   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_ksize", out_ksize_max, 1'b0);
        chk("rst_filter", out_filter, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Filter A: 5x5, word (r,c) = r*5+c+1, consumer idle
        load_filter(1'b1, 1, 1, 0, 5, 1'b0, 1'b0);
        @(negedge clk);
        chk("A_load_done", load_done, 1'b1);
        chk("A_out_valid", out_valid, 1'b1);
        chk("A_word24", out_filter[24*DATA_W +: DATA_W], 16'd25);
        chk("A_in_ready", in_ready, PP);
        @(negedge clk);
        chk("A_load_done_pulse", load_done, 1'b0);
        @(posedge clk);
        #1;

`ifndef FILTER_BUF_PINGPONG_EN
        // Single bank: a row held valid must not transfer while A is in use
        in_valid  = 1'b1;
        in_row    = make_row(7, 0, 0);
        ksize_max = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        // Row 0 of the 7s filter went in on that edge; finish it with
        // ksize_max flipped to 1, which must be ignored
        load_filter(1'b0, 7, 0, 1, 3, 1'b1, 1'b0);
`else
        // Filter B loads behind A; buffer then holds two filters
        load_filter(1'b0, 500, 2, 0, 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("B_load_done", load_done, 1'b1);
        chk("B_in_ready", in_ready, 1'b0);
        chk("B_A_still_valid", out_valid, 1'b1);
        chk("B_A_word24", out_filter[24*DATA_W +: DATA_W], 16'd25);
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("swap_out_valid", out_valid, 1'b1);
        chk("swap_in_ready", in_ready, 1'b1);
        chk("swap_ksize", out_ksize_max, 1'b0);
        @(posedge clk);
        #1;
        // Filter C: last row coincides with release of B
        load_filter(1'b1, 1000, 1, 0, 5, 1'b0, 1'b1);
        @(negedge clk);
        chk("C_out_valid", out_valid, 1'b1);
        chk("C_in_ready", in_ready, 1'b1);
        chk("C_load_done", load_done, 1'b1);
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("C_rel_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        load_filter(1'b0, 7, 0, 0, 3, 1'b1, 1'b0);
`endif

        // 3x3 of 7s: stale data in words 3..4 and rows 3..4 must read zero
        @(negedge clk);
        chk("K3_load_done", load_done, 1'b1);
        chk("K3_out_valid", out_valid, 1'b1);
        chk("K3_ksize", out_ksize_max, 1'b0);
        chk("K3_word3", out_filter[3*DATA_W +: DATA_W], 16'd0);
        chk("K3_word12", out_filter[12*DATA_W +: DATA_W], 16'd7);
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("K3_rel_out_valid", out_valid, 1'b0);

        // Release with no active filter is ignored
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("idle_rel_out_valid", out_valid, 1'b0);
        chk("idle_rel_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Signed 3x3: word (r,c) = -50 + 3*(r*5+c)
        load_filter(1'b0, -50, 3, 0, 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("S_out_valid", out_valid, 1'b1);
        chk("S_word0", out_filter[0 +: DATA_W], 16'hFFCE);
        chk("S_word12", out_filter[12*DATA_W +: DATA_W], 16'hFFF2);
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("S_rel_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Partial 5x5 load interrupted by reset after row 2
        load_filter(1'b1, 100, 1, 0, 3, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_load_done", load_done, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_filter", out_filter, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Fresh 5x5 load must contain only its own rows
        load_filter(1'b1, 200, 1, 0, 5, 1'b0, 1'b0);
        @(negedge clk);
        chk("F_out_valid", out_valid, 1'b1);
        chk("F_load_done", load_done, 1'b1);
        chk("F_word0", out_filter[0 +: DATA_W], 16'd200);
        chk("F_word24", out_filter[24*DATA_W +: DATA_W], 16'd224);
        @(posedge clk);
        #1;
        pulse_release();
        @(negedge clk);
        chk("F_rel_out_valid", out_valid, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        chk("filters_presented", presented, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
